rx_axis_pkt_fifo: RTL and testbench
===================================

Name: rx_axis_pkt_fifo

Overview:
Store-and-forward frame buffer placed directly downstream of rx_mac. It takes the raw rx_mac word stream (data, keep, valid, err), delineates frames and stores them in an internal FIFO. Only fully received, error-free frames are released on an AXI-Stream master port with tlast. Frames flagged by rx_mac (bad CRC or length) and frames that overflow the buffer are rolled back and counted, so downstream logic never sees a partial or corrupt frame.

Parameters:
DATA_WIDTH, 32, width of i_data and m_axis_tdata in bits.
KEEP_WIDTH, DATA_WIDTH/8, byte-enable width.
FIFO_DEPTH, 512, storage depth in words; must be a power of 2.
CNT_WIDTH, 16, width of the statistics counters.

Ports:
i_clk  in  1  clock; all logic is synchronous to its rising edge.
i_reset  in  1  synchronous reset, active-high.
i_data  in  DATA_WIDTH  rx_mac o_data.
i_data_keep  in  KEEP_WIDTH  rx_mac o_data_keep.
i_data_valid  in  1  rx_mac o_data_valid.
i_data_err  in  1  rx_mac o_data_err.
m_axis_tdata  out  DATA_WIDTH  output frame data.
m_axis_tkeep  out  KEEP_WIDTH  output byte enables.
m_axis_tvalid  out  1  output word valid.
m_axis_tlast  out  1  last word of frame.
m_axis_trdy  in  1  downstream ready.
o_good_frames  out  CNT_WIDTH  count of committed frames.
o_bad_frames  out  CNT_WIDTH  count of frames dropped due to an error.
o_drop_frames  out  CNT_WIDTH  count of frames dropped due to overflow.
o_fifo_level  out  $clog2(FIFO_DEPTH)+1  number of committed, unread words.

Behaviour:
- Reset: all pointers, flags and counters clear to 0. m_axis_tvalid, m_axis_tlast, m_axis_tdata and m_axis_tkeep drive 0. Any frame in progress is discarded; the first frame accepted after reset starts on a fresh word.
- Input word: a cycle with i_data_valid=1 and i_data_keep!=0. A frame is a run of consecutive input words.
- End of frame (EOF): the first cycle after at least one word where i_data_valid=0 or i_data_keep==0. rx_mac guarantees at least one such cycle between frames, so an EOF cycle never carries a word.
- Ingress stage: a single holding register, hold_word, keeps the previous word so that tlast can be attached to it.
  - A new word arriving while hold_word is full writes hold_word to the FIFO with last=0, then loads the new word into hold_word.
  - On EOF, hold_word is written with last=1 and the frame is resolved in the same cycle.
- Error sticky, err_stk: set if i_data_err=1 on any cycle from the first word through the EOF cycle inclusive. Also set if a non-final word has keep != all-ones. Cleared after each frame is resolved.
- Overflow sticky, ovf_stk: set when a write is required while the FIFO is full. Fullness is measured as wr_ptr - rd_ptr == FIFO_DEPTH. Once ovf_stk is set, no further words of that frame are written. Any frame longer than FIFO_DEPTH words is therefore always dropped.
- Resolution at EOF:
  - ovf_stk set: wr_ptr is restored to commit_ptr and o_drop_frames increments. Overflow takes priority over error.
  - else err_stk set, or i_data_err=1 in the EOF cycle: wr_ptr is restored to commit_ptr and o_bad_frames increments.
  - else: commit_ptr is set to wr_ptr including the last word written this cycle, and o_good_frames increments.
- Read side: only words below commit_ptr are visible. The output stage is a registered word buffer.
  - m_axis_tvalid rises exactly 2 cycles after the EOF cycle of a committed frame, provided the output stage was empty.
  - While m_axis_tvalid=1 and m_axis_trdy=0, tdata, tkeep and tlast hold stable.
  - With m_axis_trdy held at 1, the block delivers one word per cycle with no bubbles, including across frame boundaries.
- Simultaneous read and write: the read pointer and the write/rollback logic are independent. A rollback never moves rd_ptr or commit_ptr backwards.
- Pointers are $clog2(FIFO_DEPTH)+1 bits wide and wrap naturally. o_fifo_level = commit_ptr - rd_ptr.
- Counters saturate at all-ones and do not wrap.

Test Plan:
- 16-word frame, keep=F on every word except the last (keep=3), no err, trdy=1: 16 words out, tlast only on word 16 with tkeep=3; tvalid rises 2 cycles after EOF; o_good_frames=1.
- 16-word frame with i_data_err=1 in the EOF cycle, followed by a good 8-word frame: only the 8-word frame appears on m_axis; o_bad_frames=1, o_good_frames=1, o_fifo_level returns to 0.
- FIFO_DEPTH=32, 40-word frame: nothing is output; o_drop_frames=1; a following 10-word frame passes intact.
- trdy toggling 1/0 every cycle over 3 back-to-back 15-word frames: all 45 words are output in order with exactly 3 tlast pulses, and data is stable while stalled.
- Assert i_reset in the middle of the 6th word of a frame, then send a clean 12-word frame: the output is exactly those 12 words; all counters are 0 except o_good_frames=1.
- 70000 good frames: o_good_frames saturates at 16'hFFFF.

Source files
------------

// File: rtl/rx_axis_pkt_fifo.sv
// Store-and-forward frame buffer behind rx_mac: frames are staged in a FIFO and
// released on AXI-Stream only once complete and clean; bad/overflowed frames roll back.
module rx_axis_pkt_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int KEEP_WIDTH = DATA_WIDTH/8,
  parameter int FIFO_DEPTH = 512,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic [DATA_WIDTH-1:0]         i_data,
  input  logic [KEEP_WIDTH-1:0]         i_data_keep,
  input  logic                          i_data_valid,
  input  logic                          i_data_err,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]         m_axis_tkeep,
  output logic                          m_axis_tvalid,
  output logic                          m_axis_tlast,
  input  logic                          m_axis_trdy,
  output logic [CNT_WIDTH-1:0]          o_good_frames,
  output logic [CNT_WIDTH-1:0]          o_bad_frames,
  output logic [CNT_WIDTH-1:0]          o_drop_frames,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  typedef struct packed {
    logic                  last;
    logic [KEEP_WIDTH-1:0] keep;
    logic [DATA_WIDTH-1:0] data;
  } ent_t;

  ent_t                  mem [FIFO_DEPTH];
  ent_t                  rd_ent;
  logic [PW-1:0]         wr_ptr, commit_ptr, rd_ptr;
  logic                  hold_vld;
  logic [DATA_WIDTH-1:0] hold_data;
  logic [KEEP_WIDTH-1:0] hold_keep;
  logic                  err_stk, ovf_stk;

  logic in_word, eof, full, ovf_now, wr_en, keep_err, err_now, ovf_any, err_any, load;
  logic [PW-1:0] wr_ptr_inc;

  // hold_word is full exactly while a frame is open, so every open-frame cycle writes one word
  assign in_word    = i_data_valid && (i_data_keep != '0);
  assign eof        = hold_vld && !in_word;
  assign full       = (wr_ptr - rd_ptr) == PW'(FIFO_DEPTH);
  assign ovf_now    = hold_vld && (ovf_stk || full);
  assign wr_en      = hold_vld && !ovf_now;
  assign keep_err   = hold_vld && in_word && (hold_keep != '1);
  assign err_now    = i_data_err && (hold_vld || in_word);
  assign ovf_any    = ovf_stk || ovf_now;
  assign err_any    = err_stk || keep_err || err_now;
  assign wr_ptr_inc = wr_ptr + 1'b1;

  assign rd_ent       = mem[rd_ptr[AW-1:0]];
  assign load         = (commit_ptr != rd_ptr) && (!m_axis_tvalid || m_axis_trdy);
  assign o_fifo_level = commit_ptr - rd_ptr;

  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= '{last: eof, keep: hold_keep, data: hold_data};
  end

  // Ingress: hold register, stickies and commit/rollback
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      hold_vld      <= 1'b0;
      hold_data     <= '0;
      hold_keep     <= '0;
      err_stk       <= 1'b0;
      ovf_stk       <= 1'b0;
      wr_ptr        <= '0;
      commit_ptr    <= '0;
      o_good_frames <= '0;
      o_bad_frames  <= '0;
      o_drop_frames <= '0;
    end else begin
      hold_vld <= in_word;
      if (in_word) begin
        hold_data <= i_data;
        hold_keep <= i_data_keep;
      end
      if (eof) begin
        err_stk <= 1'b0;
        ovf_stk <= 1'b0;
        if (ovf_any) begin
          wr_ptr <= commit_ptr;
          if (o_drop_frames != '1) o_drop_frames <= o_drop_frames + 1'b1;
        end else if (err_any) begin
          wr_ptr <= commit_ptr;
          if (o_bad_frames != '1) o_bad_frames <= o_bad_frames + 1'b1;
        end else begin
          wr_ptr     <= wr_ptr_inc;
          commit_ptr <= wr_ptr_inc;
          if (o_good_frames != '1) o_good_frames <= o_good_frames + 1'b1;
        end
      end else begin
        if (wr_en)              wr_ptr  <= wr_ptr_inc;
        if (err_now || keep_err) err_stk <= 1'b1;
        if (ovf_now)            ovf_stk <= 1'b1;
      end
    end
  end

  // Egress: one-word output register refilled on the same cycle it is consumed
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rd_ptr        <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
    end else if (load) begin
      rd_ptr        <= rd_ptr + 1'b1;
      m_axis_tvalid <= 1'b1;
      m_axis_tlast  <= rd_ent.last;
      m_axis_tkeep  <= rd_ent.keep;
      m_axis_tdata  <= rd_ent.data;
    end else if (m_axis_trdy) begin
      m_axis_tvalid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_rx_axis_pkt_fifo.sv
// Scoreboard bench for rx_axis_pkt_fifo: stimulus pushes expected words, a negedge
// monitor pops and compares every accepted beat and checks stall stability.
module tb_rx_axis_pkt_fifo;
  localparam int DW = 32;
  localparam int KW = 4;
  localparam int DEPTH = 32;
  localparam int CW = 8;    // narrow counters so saturation is reachable quickly
  localparam int EW = 1 + KW + DW;

  logic          i_clk = 1'b0;
  logic          i_reset = 1'b1;
  logic [DW-1:0] i_data = '0;
  logic [KW-1:0] i_data_keep = '0;
  logic          i_data_valid = 1'b0;
  logic          i_data_err = 1'b0;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic          m_axis_tvalid, m_axis_tlast;
  logic          m_axis_trdy;
  logic [CW-1:0] o_good_frames, o_bad_frames, o_drop_frames;
  logic [$clog2(DEPTH):0] o_fifo_level;

  rx_axis_pkt_fifo #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_data(i_data), .i_data_keep(i_data_keep),
    .i_data_valid(i_data_valid), .i_data_err(i_data_err),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_trdy(m_axis_trdy),
    .o_good_frames(o_good_frames), .o_bad_frames(o_bad_frames), .o_drop_frames(o_drop_frames),
    .o_fifo_level(o_fifo_level)
  );

  always #5 i_clk = !i_clk;

  int n_chk = 0;
  int n_pass = 0;
  logic [EW-1:0] sb[$];
  logic tog_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // trdy: held high, or toggled every cycle when tog_en is set
  initial begin
    m_axis_trdy = 1'b1;
    forever begin
      @(posedge i_clk); #1;
      m_axis_trdy = tog_en ? !m_axis_trdy : 1'b1;
    end
  end

  // Monitor
  initial begin
    logic          p_vld, p_rdy;
    logic [EW-1:0] p_word, exp_w;
    p_vld = 1'b0; p_rdy = 1'b0; p_word = '0;
    forever begin
      @(negedge i_clk);
      if (!i_reset) begin
        if (p_vld && !p_rdy)
          chk("stall_hold", 64'({m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata}),
              64'({1'b1, p_word}));
        if (m_axis_tvalid && m_axis_trdy) begin
          if (sb.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_word: got %0h expected none",
                     {m_axis_tlast, m_axis_tkeep, m_axis_tdata});
          end else begin
            exp_w = sb.pop_front();
            chk("out_word", 64'({m_axis_tlast, m_axis_tkeep, m_axis_tdata}), 64'(exp_w));
          end
        end
      end
      p_vld  = m_axis_tvalid;
      p_rdy  = m_axis_trdy;
      p_word = {m_axis_tlast, m_axis_tkeep, m_axis_tdata};
    end
  end

  task automatic step();
    @(posedge i_clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      i_data_valid = 1'b0; i_data_keep = '0; i_data_err = 1'b0;
    end
  endtask

  // n words from base; last word keep=lkeep; word kbad (if >=0) gets keep=3;
  // EOF cycle carries eof_err. Ends right after driving the EOF cycle.
  task automatic send_frame(input int n, input logic [DW-1:0] base, input logic [KW-1:0] lkeep,
                            input logic eof_err, input int kbad, input logic push);
    logic [KW-1:0] k;
    for (int i = 0; i < n; i++) begin
      step();
      k = (i == n-1) ? lkeep : ((i == kbad) ? 4'h3 : 4'hF);
      i_data_valid = 1'b1; i_data = base + DW'(i); i_data_keep = k; i_data_err = 1'b0;
      if (push) sb.push_back({(i == n-1), k, base + DW'(i)});
    end
    step();
    i_data_valid = 1'b0; i_data_keep = '0; i_data_err = eof_err;
  endtask

  task automatic drain();
    for (int i = 0; i < 600 && sb.size() != 0; i++) @(negedge i_clk);
    chk("drain_empty", 64'(sb.size()), 64'(0));
    idle(3);
  endtask

  task automatic chk_cnt(input string tag, input int g, input int b, input int d);
    @(negedge i_clk);
    chk({tag, "_good"}, 64'(o_good_frames), 64'(g));
    chk({tag, "_bad"},  64'(o_bad_frames),  64'(b));
    chk({tag, "_drop"}, 64'(o_drop_frames), 64'(d));
    chk({tag, "_level"}, 64'(o_fifo_level), 64'(0));
  endtask

  initial begin
    repeat (3) @(posedge i_clk);
    #1 i_reset = 1'b0;
    @(negedge i_clk);
    chk("rst_tvalid", 64'(m_axis_tvalid), 64'(0));
    chk("rst_tout", 64'({m_axis_tlast, m_axis_tkeep, m_axis_tdata}), 64'(0));
    chk_cnt("rst", 0, 0, 0);

    // 16-word frame, last keep=3, latency check
    send_frame(16, 32'hA000_0000, 4'h3, 1'b0, -1, 1'b1);
    @(negedge i_clk);                         // EOF cycle
    @(negedge i_clk);
    chk("lat_eof_plus1", 64'(m_axis_tvalid), 64'(0));
    @(negedge i_clk);
    chk("lat_eof_plus2", 64'(m_axis_tvalid), 64'(1));
    drain();
    chk_cnt("t1", 1, 0, 0);

    // error at EOF then good 8-word frame
    send_frame(16, 32'hB000_0000, 4'hF, 1'b1, -1, 1'b0);
    send_frame(8,  32'hB100_0000, 4'hF, 1'b0, -1, 1'b1);
    drain();
    chk_cnt("t2", 2, 1, 0);

    // non-final word with partial keep is an error
    send_frame(5, 32'hB200_0000, 4'hF, 1'b0, 2, 1'b0);
    idle(1);
    drain();
    chk_cnt("t2k", 2, 2, 0);

    // overflow: 40 words into a 32-deep buffer, then 10-word frame
    send_frame(40, 32'hC000_0000, 4'hF, 1'b0, -1, 1'b0);
    send_frame(10, 32'hC100_0000, 4'h1, 1'b0, -1, 1'b1);
    drain();
    chk_cnt("t3", 3, 2, 1);

    // trdy toggling over 3 back-to-back 15-word frames
    tog_en = 1'b1;
    send_frame(15, 32'hD000_0000, 4'hF, 1'b0, -1, 1'b1);
    send_frame(15, 32'hD100_0000, 4'hF, 1'b0, -1, 1'b1);
    send_frame(15, 32'hD200_0000, 4'h7, 1'b0, -1, 1'b1);
    drain();
    tog_en = 1'b0;
    idle(2);
    chk_cnt("t4", 6, 2, 1);

    // reset during 6th word, then a clean 12-word frame
    for (int i = 0; i < 5; i++) begin
      step();
      i_data_valid = 1'b1; i_data = 32'hE000_0000 + i; i_data_keep = 4'hF;
    end
    step();
    i_data = 32'hE000_0005; i_reset = 1'b1;
    step();
    i_reset = 1'b0; i_data_valid = 1'b0; i_data_keep = '0;
    send_frame(12, 32'hE100_0000, 4'hF, 1'b0, -1, 1'b1);
    drain();
    chk_cnt("t5", 1, 0, 0);

    // counter saturation
    for (int f = 0; f < 253; f++) send_frame(1, 32'hF000_0000 + f, 4'hF, 1'b0, -1, 1'b1);
    drain();
    chk_cnt("sat_fe", 254, 0, 0);
    for (int f = 0; f < 47; f++) send_frame(1, 32'hF100_0000 + f, 4'h8, 1'b0, -1, 1'b1);
    drain();
    chk_cnt("sat_ff", 255, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
